// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one single-port SRAM among NUM_REQ clients
//
// Ports:
//   i_clk, i_nrst        clock, asynchronous active-low reset
//   i_req_*              per-requester valid/op/addr/wdata/bitmask (flattened, requester k at slice k)
//   o_req_ready          one-hot grant, handshake = valid & ready
//   o_rsp_valid/data     one-hot read response, data shared and passed through from the SRAM
//   o_sram_*, i_sram_rdata  registered SRAM control and its read data
module sram_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DEPTH      = 64,
   parameter int SRAM_WIDTH = 64,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                             i_clk,
   input  logic                             i_nrst,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   input  logic [NUM_REQ-1:0]               i_req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
   input  logic [NUM_REQ*SRAM_WIDTH-1:0]    i_req_wdata,
   input  logic [NUM_REQ*SRAM_WIDTH-1:0]    i_req_bitmask,
   output logic [NUM_REQ-1:0]               o_req_ready,
   output logic [NUM_REQ-1:0]               o_rsp_valid,
   output logic [SRAM_WIDTH-1:0]            o_rsp_data,
   output logic                             o_sram_en_n,
   output logic                             o_sram_we,
   output logic [ADDR_WIDTH-1:0]            o_sram_addr,
   output logic [SRAM_WIDTH-1:0]            o_sram_wdata,
   output logic [SRAM_WIDTH-1:0]            o_sram_bitmask,
   input  logic [SRAM_WIDTH-1:0]            i_sram_rdata
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  en_n_q, en_n_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SRAM_WIDTH-1:0] wdata_q, wdata_d;
   logic [SRAM_WIDTH-1:0] bitmask_q, bitmask_d;
   // Two-stage read tag: stage 1 = SRAM inputs being driven, stage 2 = SRAM output valid
   logic                  tag1_valid_q, tag1_valid_d;
   logic [PTR_W-1:0]      tag1_id_q, tag1_id_d;
   logic                  tag2_valid_q, tag2_valid_d;
   logic [PTR_W-1:0]      tag2_id_q, tag2_id_d;

   logic [NUM_REQ-1:0]    grant;
   logic [PTR_W-1:0]      grant_id;
   logic                  found;
   int                    scan;

   // Scan from the pointer upward, wrapping modulo NUM_REQ; first valid wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      scan     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan = int'(ptr_q) + i;
         if (scan >= NUM_REQ) scan = scan - NUM_REQ;
         if (!found && i_req_valid[scan]) begin
            found    = 1'b1;
            grant_id = PTR_W'(scan);
         end
      end
      if (found) grant[grant_id] = 1'b1;
   end

   // No grant may be presented while reset is held.
   assign o_req_ready = grant & {NUM_REQ{i_nrst}};

   always_comb begin
      ptr_d        = ptr_q;
      en_n_d       = 1'b1;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      bitmask_d    = bitmask_q;
      tag1_valid_d = 1'b0;
      tag1_id_d    = tag1_id_q;
      tag2_valid_d = tag1_valid_q;
      tag2_id_d    = tag1_id_q;
      if (found) begin
         ptr_d     = (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
         en_n_d    = 1'b0;
         we_d      = i_req_write[grant_id];
         addr_d    = i_req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_d   = i_req_wdata[int'(grant_id)*SRAM_WIDTH +: SRAM_WIDTH];
         // Reads never carry a write mask to the SRAM.
         bitmask_d = i_req_write[grant_id] ?
                     i_req_bitmask[int'(grant_id)*SRAM_WIDTH +: SRAM_WIDTH] : '0;
         tag1_valid_d = ~i_req_write[grant_id];
         tag1_id_d    = grant_id;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ptr_q        <= '0;
         en_n_q       <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         bitmask_q    <= '0;
         tag1_valid_q <= 1'b0;
         tag1_id_q    <= '0;
         tag2_valid_q <= 1'b0;
         tag2_id_q    <= '0;
      end else begin
         ptr_q        <= ptr_d;
         en_n_q       <= en_n_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         bitmask_q    <= bitmask_d;
         tag1_valid_q <= tag1_valid_d;
         tag1_id_q    <= tag1_id_d;
         tag2_valid_q <= tag2_valid_d;
         tag2_id_q    <= tag2_id_d;
      end
   end

   always_comb begin
      o_rsp_valid = '0;
      if (tag2_valid_q) o_rsp_valid[tag2_id_q] = 1'b1;
   end

   assign o_rsp_data     = i_sram_rdata;
   assign o_sram_en_n    = en_n_q;
   assign o_sram_we      = we_q;
   assign o_sram_addr    = addr_q;
   assign o_sram_wdata   = wdata_q;
   assign o_sram_bitmask = bitmask_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;

   localparam int NR = 2;
   localparam int AW = 6;
   localparam int DW = 64;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            nrst;
   logic [NR-1:0]   req_valid, req_write, req_ready, rsp_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata, req_bitmask;
   logic [DW-1:0]   rsp_data, sram_wdata, sram_bitmask, sram_rdata;
   logic            sram_en_n, sram_we;
   logic [AW-1:0]   sram_addr;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.NUM_REQ(NR), .DEPTH(64), .SRAM_WIDTH(DW)) dut (
      .i_clk(clk), .i_nrst(nrst),
      .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .i_req_bitmask(req_bitmask),
      .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
      .o_sram_en_n(sram_en_n), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
      .o_sram_wdata(sram_wdata), .o_sram_bitmask(sram_bitmask),
      .i_sram_rdata(sram_rdata)
   );

   // Behavioural single-port SRAM: registered read, byte b written iff mask bit 8b set.
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (!sram_en_n) begin
         if (sram_we) begin
            for (int b = 0; b < DW/8; b++)
               if (sram_bitmask[8*b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  write;
      logic [5:0]  addr0;
      logic [5:0]  addr1;
      logic [63:0] wdata0;
      logic [63:0] mask0;
      logic [1:0]  e_ready;
      logic        e_en_n;
      logic        e_we;
      logic [5:0]  e_addr;
      logic [63:0] e_mask;
      logic [1:0]  e_rsp;
      logic [63:0] e_data;
   } vec_t;

   vec_t tbl [26];

   function automatic vec_t mk(logic [1:0] v, logic [1:0] w, logic [5:0] a0, logic [5:0] a1,
                               logic [63:0] wd0, logic [63:0] m0, logic [1:0] er, logic een,
                               logic ewe, logic [5:0] ea, logic [63:0] em, logic [1:0] ersp,
                               logic [63:0] ed);
      vec_t r;
      r.valid = v; r.write = w; r.addr0 = a0; r.addr1 = a1; r.wdata0 = wd0; r.mask0 = m0;
      r.e_ready = er; r.e_en_n = een; r.e_we = ewe; r.e_addr = ea; r.e_mask = em;
      r.e_rsp = ersp; r.e_data = ed;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic drive_idle();
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_bitmask = '0;
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = '0;
      sram_rdata = '0;

      //     valid  write  a0 a1 wdata0                 mask0    ready en_n we addr mask     rsp    data
      tbl[0]  = mk(2'b11, 2'b01, 5, 5, 64'hDEADBEEF_00000001, ONES,  2'b01, 1, 0, 0,  0,       2'b00, 0);
      tbl[1]  = mk(2'b10, 2'b00, 0, 5, 0, 0,                         2'b10, 0, 1, 5,  ONES,    2'b00, 0);
      tbl[2]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 0, 0, 5,  0,       2'b00, 0);
      tbl[3]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 1, 0, 5,  0,       2'b10, 64'hDEADBEEF_00000001);
      tbl[4]  = mk(2'b01, 2'b01, 3, 0, ONES, 64'h101,                2'b01, 1, 0, 5,  0,       2'b00, 0);
      tbl[5]  = mk(2'b10, 2'b00, 0, 3, 0, 0,                         2'b10, 0, 1, 3,  64'h101, 2'b00, 0);
      tbl[6]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 0, 0, 3,  0,       2'b00, 0);
      tbl[7]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 1, 0, 3,  0,       2'b10, 64'h0000_0000_0000_FFFF);
      tbl[8]  = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b01, 1, 0, 3,  0,       2'b00, 0);
      tbl[9]  = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b10, 0, 0, 1,  0,       2'b00, 0);
      tbl[10] = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b01, 0, 0, 2,  0,       2'b01, 0);
      tbl[11] = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b10, 0, 0, 1,  0,       2'b10, 0);
      tbl[12] = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b01, 0, 0, 2,  0,       2'b01, 0);
      tbl[13] = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b10, 0, 0, 1,  0,       2'b10, 0);
      tbl[14] = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b01, 0, 0, 2,  0,       2'b01, 0);
      tbl[15] = mk(2'b11, 2'b00, 1, 2, 0, 0,                         2'b10, 0, 0, 1,  0,       2'b10, 0);
      tbl[16] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 0, 0, 2,  0,       2'b01, 0);
      tbl[17] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 1, 0, 2,  0,       2'b10, 0);
      tbl[18] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 1, 0, 2,  0,       2'b00, 0);
      tbl[19] = mk(2'b01, 2'b01, 10, 0, 64'hA5, ONES,                2'b01, 1, 0, 2,  0,       2'b00, 0);
      tbl[20] = mk(2'b10, 2'b00, 0, 10, 0, 0,                        2'b10, 0, 1, 10, ONES,    2'b00, 0);
      tbl[21] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 0, 0, 10, 0,       2'b00, 0);
      tbl[22] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 1, 0, 10, 0,       2'b10, 64'hA5);
      tbl[23] = mk(2'b10, 2'b00, 0, 5, 0, 0,                         2'b10, 1, 0, 10, 0,       2'b00, 0);
      tbl[24] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 0, 0, 5,  0,       2'b00, 0);
      tbl[25] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 1, 0, 5,  0,       2'b10, 64'hDEADBEEF_00000001);

      // Reset held with every requester asking.
      nrst = 1'b0;
      drive_idle();
      req_valid = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 64'(req_ready), 64'(2'b00));
      chk("reset_en_n", 64'(sram_en_n), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(2'b00));
      chk("reset_addr", 64'(sram_addr), 64'd0);
      @(posedge clk); #1;
      drive_idle();
      nrst = 1'b1;

      for (int i = 0; i < 26; i++) begin
         @(posedge clk); #1;
         req_valid   = tbl[i].valid;
         req_write   = tbl[i].write;
         req_addr    = {tbl[i].addr1, tbl[i].addr0};
         req_wdata   = {64'h0, tbl[i].wdata0};
         req_bitmask = {64'h0, tbl[i].mask0};
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
         chk($sformatf("v%0d_en_n", i), 64'(sram_en_n), 64'(tbl[i].e_en_n));
         chk($sformatf("v%0d_we", i), 64'(sram_we), 64'(tbl[i].e_we));
         chk($sformatf("v%0d_addr", i), 64'(sram_addr), 64'(tbl[i].e_addr));
         chk($sformatf("v%0d_mask", i), sram_bitmask, tbl[i].e_mask);
         chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_rsp));
         if (tbl[i].e_rsp != 2'b00)
            chk($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].e_data);
      end

      // Reset arriving the cycle after a read handshake drops the read.
      @(posedge clk); #1;
      drive_idle();
      req_valid = 2'b01;
      req_addr  = {6'd0, 6'd5};
      @(negedge clk);
      chk("midrst_ready", 64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      drive_idle();
      nrst = 1'b0;
      @(negedge clk);
      chk("midrst_en_n", 64'(sram_en_n), 64'd1);
      chk("midrst_rsp_in_reset", 64'(rsp_valid), 64'(2'b00));
      @(posedge clk); #1;
      nrst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_rsp_after_%0d", c), 64'(rsp_valid), 64'(2'b00));
         @(posedge clk); #1;
      end

      // Pointer is back at 0 after the reset.
      req_valid = 2'b11;
      @(negedge clk);
      chk("midrst_ptr_reset", 64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      drive_idle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares one single-port `sram` instance (active-low enable, 0=read/1=write, byte-lane write bitmask, registered read data) among NUM_REQ requesters.
- Sits between the SRAM and its clients, e.g. the DMA loader (writes) and the PE-array feeder (reads).
- Accepts at most one request per cycle and drives registered SRAM control signals.
- Routes each read result back to the requester that issued it, with a fixed 2-cycle latency.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DEPTH, 64, SRAM depth in words; ADDR_WIDTH = $clog2(DEPTH) (localparam).
- SRAM_WIDTH, 64, word width in bits (multiple of 8).

Ports:
- i_clk  input  1  clock.
- i_nrst  input  1  reset; asynchronous, active-low.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- i_req_write  input  NUM_REQ  per-requester op: 0=read, 1=write.
- i_req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_wdata  input  NUM_REQ*SRAM_WIDTH  flattened write data.
- i_req_bitmask  input  NUM_REQ*SRAM_WIDTH  flattened write bitmask; byte b is written iff bit 8b is set.
- o_req_ready  output  NUM_REQ  one-hot grant; handshake = valid & ready.
- o_rsp_valid  output  NUM_REQ  one-hot read-response valid.
- o_rsp_data  output  SRAM_WIDTH  read data, shared by all requesters, qualified by o_rsp_valid.
- o_sram_en_n  output  1  to SRAM i_active_low_en.
- o_sram_we  output  1  to SRAM i_read_write_en.
- o_sram_addr  output  ADDR_WIDTH  to SRAM i_addr.
- o_sram_wdata  output  SRAM_WIDTH  to SRAM i_data_in.
- o_sram_bitmask  output  SRAM_WIDTH  to SRAM i_write_bitmask.
- i_sram_rdata  input  SRAM_WIDTH  from SRAM o_data_out.

Behaviour:
- Reset (async, i_nrst=0):
  - o_sram_en_n=1; o_sram_we, o_sram_addr, o_sram_wdata, o_sram_bitmask = 0.
  - Response pipeline cleared: o_rsp_valid=0.
  - Round-robin pointer = 0.
  - o_req_ready=0 while in reset.
- Reset mid-operation: any in-flight read is dropped and no response is issued after reset release.
- Arbitration (combinational, same cycle):
  - Grant the first valid requester found by scanning from the pointer upward, modulo NUM_REQ.
  - o_req_ready is one-hot on the winner; all zeros if no request is valid.
  - Ready depends on valid; a requester must not withdraw valid until its handshake.
- Pointer update at the clock edge:
  - After a grant to k, pointer = (k+1) mod NUM_REQ.
  - With no grant, the pointer is unchanged.
  - A continuously requesting client is therefore served at least once every NUM_REQ cycles.
- Issue stage (registered), for a handshake in cycle T:
  - In cycle T+1: o_sram_en_n=0, o_sram_we=i_req_write[k], and addr/wdata/bitmask are copied from requester k.
  - With no handshake in T: o_sram_en_n=1 in T+1; other SRAM outputs hold their last value.
  - Reads drive o_sram_bitmask=0.
- Response pipeline:
  - A 2-stage tag pipeline carries {is_read, requester id}.
  - For a read handshaked in T: o_rsp_valid[k]=1 for exactly cycle T+2, and o_rsp_data=i_sram_rdata (combinational pass-through).
  - Writes produce no response.
  - When o_rsp_valid=0, o_rsp_data is undefined to consumers (pass-through is allowed).
- Throughput:
  - One access per cycle, with no bubbles between back-to-back requests, including read→write and write→read.
  - Reads are fully pipelined: up to 2 responses are in flight.
- Ordering:
  - Same-address write in T then read in T+1 returns the new data.
  - The SRAM applies the write at the end of T+1 and the read samples at the end of T+2.
- Responses: no backpressure; requesters must accept o_rsp_valid in the cycle it is asserted.
- Simultaneous events: at most one grant per cycle; losers keep valid asserted and wait.

Test Plan:
- Reset: hold i_nrst=0 with all i_req_valid=1 -> o_req_ready=0, o_sram_en_n=1, o_rsp_valid=0. After release, requester 0 is granted first.
- Single read: requester 1 reads addr 5, which holds 0xDEADBEEF_00000001 (preloaded by a write) -> o_sram_en_n=0 and we=0 one cycle after the handshake; o_rsp_valid=2'b10 with that data exactly 2 cycles after the handshake.
- Byte-masked write: requester 0 writes 0xFFFF_FFFF_FFFF_FFFF to addr 3, which holds 0, with bitmask bits 0 and 8 set -> a later read of addr 3 returns 0x0000_0000_0000_FFFF.
- Fairness: both requesters hold valid for 8 cycles -> grants alternate 0,1,0,1,… with one SRAM access per cycle and no idle cycle.
- Write-then-read: requester 0 writes 0xA5 to addr 10 in cycle T; requester 1 reads addr 10 in T+1 -> requester 1 receives 0xA5 in T+3.
- Reset mid-read: handshake a read, assert i_nrst=0 the next cycle, then release -> no o_rsp_valid pulse ever appears for that read.
